// File: rtl/icebreaker_system_fabric.sv
`timescale 1ns/1ps
// icebreaker_system_fabric: reset synchronizer, fetch/load-store arbiter in
// front of a single-port EBR, plus a small peripheral block (LED register,
// 64-bit cycle counter with a high-word shadow).
//
// state | meaning
// IDLE  | pick a requester, issue the EBR access combinationally
// IRESP | instr_gnt high, fetch data valid this cycle
// DRESP | data_gnt high, load data valid this cycle
module icebreaker_system_fabric #(
    parameter int MEM_AW     = 10,
    parameter int RST_STAGES = 2,
    parameter int NUM_LED    = 3
) (
    input  logic               clk,
    input  logic               RSTN,
    output logic               rstz,

    input  logic [31:0]        instr_addr,
    input  logic               instr_req,
    output logic [31:0]        instr_data,
    output logic               instr_gnt,

    input  logic [31:0]        data_addr,
    input  logic [31:0]        data_wr_data,
    input  logic [3:0]         data_wr_mask,
    input  logic               data_rd_req,
    input  logic               data_wr_req,
    output logic [31:0]        data_rd_data,
    output logic               data_gnt,

    output logic [MEM_AW-1:0]  mem_addr,
    output logic [31:0]        mem_wr_data,
    output logic [3:0]         mem_wr_mask,
    output logic               mem_en,
    output logic               mem_wr_en,
    input  logic [31:0]        mem_rd_data,

    output logic [NUM_LED-1:0] led
);

    localparam logic [31:0] MEM_BYTES   = 32'(64'(4) << MEM_AW);
    localparam logic [31:0] LED_ADDR    = 32'h8000_0000;
    localparam logic [31:0] CNT_LO_ADDR = 32'h8000_0004;
    localparam logic [31:0] CNT_HI_ADDR = 32'h8000_0008;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IRESP = 2'd1,
        DRESP = 2'd2
    } state_t;

    state_t              state;
    logic [RST_STAGES-1:0] rst_sync;
    logic                last_data;
    logic                resp_mem;
    logic [31:0]         resp_data;
    logic [63:0]         cycle_cnt;
    logic [31:0]         shadow;

    logic                data_req;
    logic                pick_data;
    logic                pick_instr;
    logic                instr_in_mem;
    logic                data_in_mem;
    logic [31:0]         periph_rd;
    logic [NUM_LED-1:0]  led_mask;

    // Reset synchronizer: asserts asynchronously, releases after RST_STAGES edges.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) rst_sync <= '0;
        else       rst_sync <= {rst_sync[RST_STAGES-2:0], 1'b1};
    end

    assign rstz = rst_sync[RST_STAGES-1];

    assign data_req     = data_rd_req | data_wr_req;
    assign instr_in_mem = (instr_addr < MEM_BYTES);
    assign data_in_mem  = (data_addr < MEM_BYTES);

    // Requester selection in IDLE: round-robin on contention, last winner yields.
    always_comb begin
        pick_data  = 1'b0;
        pick_instr = 1'b0;
        if (rstz && state == IDLE) begin
            if (data_req && instr_req) begin
                if (last_data) pick_instr = 1'b1;
                else           pick_data  = 1'b1;
            end else if (data_req) begin
                pick_data = 1'b1;
            end else if (instr_req) begin
                pick_instr = 1'b1;
            end
        end
    end

    assign mem_en      = (pick_data && data_in_mem) || (pick_instr && instr_in_mem);
    assign mem_wr_en   = pick_data && data_in_mem && data_wr_req;
    assign mem_addr    = pick_data ? data_addr[MEM_AW+1:2] : instr_addr[MEM_AW+1:2];
    assign mem_wr_data = data_wr_data;
    assign mem_wr_mask = data_wr_mask;

    // Peripheral read mux, sampled in IDLE so the counter value is the one at grant time.
    always_comb begin
        periph_rd = '0;
        case (data_addr)
            LED_ADDR:    periph_rd[NUM_LED-1:0] = led;
            CNT_LO_ADDR: periph_rd = cycle_cnt[31:0];
            CNT_HI_ADDR: periph_rd = shadow;
            default:     periph_rd = '0;
        endcase
    end

    // Expand byte-lane write mask onto the LED bits.
    always_comb begin
        led_mask = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            led_mask[i] = data_wr_mask[2'(i / 8)];
        end
    end

    // Arbiter FSM, peripheral registers and cycle counter.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            instr_gnt <= 1'b0;
            data_gnt  <= 1'b0;
            last_data <= 1'b0;
            resp_mem  <= 1'b0;
            resp_data <= '0;
            led       <= '0;
            cycle_cnt <= '0;
            shadow    <= '0;
        end else if (!rstz) begin
            state     <= IDLE;
            instr_gnt <= 1'b0;
            data_gnt  <= 1'b0;
            last_data <= 1'b0;
            resp_mem  <= 1'b0;
            resp_data <= '0;
            led       <= '0;
            cycle_cnt <= '0;
            shadow    <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            instr_gnt <= 1'b0;
            data_gnt  <= 1'b0;
            resp_mem  <= 1'b0;
            resp_data <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_data) begin
                        state     <= DRESP;
                        data_gnt  <= 1'b1;
                        last_data <= 1'b1;
                        if (data_wr_req) begin
                            // writes return 0; counter addresses are read-only
                            if (data_addr == LED_ADDR)
                                led <= (led & ~led_mask) | (data_wr_data[NUM_LED-1:0] & led_mask);
                        end else begin
                            resp_mem <= data_in_mem;
                            if (data_addr[31:28] == 4'h8)
                                resp_data <= periph_rd;
                            if (data_addr == CNT_LO_ADDR)
                                shadow <= cycle_cnt[63:32];
                        end
                    end else if (pick_instr) begin
                        state     <= IRESP;
                        instr_gnt <= 1'b1;
                        last_data <= 1'b0;
                        resp_mem  <= instr_in_mem;
                    end
                end
                IRESP:   state <= IDLE;
                DRESP:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign instr_data   = (instr_gnt && resp_mem) ? mem_rd_data : '0;
    assign data_rd_data = data_gnt ? (resp_mem ? mem_rd_data : resp_data) : '0;

endmodule

// File: tb/tb_icebreaker_system_fabric.sv
`timescale 1ns/1ps
// Directed bench for icebreaker_system_fabric with a behavioural EBR model.
module tb_icebreaker_system_fabric;

    localparam int MEM_AW     = 10;
    localparam int RST_STAGES = 2;
    localparam int NUM_LED    = 3;

    localparam logic [31:0] LED_A = 32'h8000_0000;
    localparam logic [31:0] CLO_A = 32'h8000_0004;
    localparam logic [31:0] CHI_A = 32'h8000_0008;

    logic               clk = 1'b0;
    logic               RSTN;
    logic               rstz;
    logic [31:0]        instr_addr;
    logic               instr_req;
    logic [31:0]        instr_data;
    logic               instr_gnt;
    logic [31:0]        data_addr;
    logic [31:0]        data_wr_data;
    logic [3:0]         data_wr_mask;
    logic               data_rd_req;
    logic               data_wr_req;
    logic [31:0]        data_rd_data;
    logic               data_gnt;
    logic [MEM_AW-1:0]  mem_addr;
    logic [31:0]        mem_wr_data;
    logic [3:0]         mem_wr_mask;
    logic               mem_en;
    logic               mem_wr_en;
    logic [31:0]        mem_rd_data;
    logic [NUM_LED-1:0] led;

    always #5 clk = ~clk;

    icebreaker_system_fabric #(
        .MEM_AW(MEM_AW), .RST_STAGES(RST_STAGES), .NUM_LED(NUM_LED)
    ) dut (
        .clk(clk), .RSTN(RSTN), .rstz(rstz),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_data(instr_data), .instr_gnt(instr_gnt),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
        .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
        .data_rd_data(data_rd_data), .data_gnt(data_gnt),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data),
        .led(led)
    );

    // EBR model: unwritten words read back as 0xA000_0000 | word index.
    logic [31:0]   ram [0:1023];
    logic [1023:0] written = '0;
    always @(posedge clk) begin
        logic [31:0] cur;
        if (mem_en) begin
            cur = written[mem_addr] ? ram[mem_addr] : (32'hA000_0000 | 32'(mem_addr));
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wr_mask[b]) cur[8*b +: 8] = mem_wr_data[8*b +: 8];
                ram[mem_addr]     <= cur;
                written[mem_addr] <= 1'b1;
            end
            mem_rd_data <= cur;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0]       rd;
    int                lat;
    logic              men_seen;
    logic              wen_seen;
    logic [MEM_AW-1:0] addr_seen;
    logic              gnt_seen;

    // One data-port transaction; returns latency to gnt and the granted read data.
    task automatic data_acc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                            input logic rd_r, input logic wr_r);
        @(negedge clk);
        data_addr = a; data_wr_data = wd; data_wr_mask = m;
        data_rd_req = rd_r; data_wr_req = wr_r;
        #1;
        men_seen = mem_en; wen_seen = mem_wr_en; addr_seen = mem_addr;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (mem_en) men_seen = 1'b1;
            if (data_gnt) break;
        end
        rd = data_rd_data;
        data_rd_req = 1'b0; data_wr_req = 1'b0;
    endtask

    task automatic instr_acc(input logic [31:0] a);
        @(negedge clk);
        instr_addr = a; instr_req = 1'b1;
        #1;
        men_seen = mem_en; addr_seen = mem_addr;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (mem_en) men_seen = 1'b1;
            if (instr_gnt) break;
        end
        rd = instr_data;
        instr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0;
        instr_addr = '0; instr_req = 1'b0;
        data_addr = '0; data_wr_data = '0; data_wr_mask = '0;
        data_rd_req = 1'b0; data_wr_req = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rstz", rstz, 0);
        chk("rst_gnt", {instr_gnt, data_gnt}, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_led", led, 0);

        // release: rstz rises exactly RST_STAGES edges later
        RSTN = 1'b1;
        for (int k = 1; k <= RST_STAGES; k++) begin
            @(posedge clk); #1;
            chk("rel_rstz", rstz, (k == RST_STAGES));
            chk("rel_no_gnt", {instr_gnt, data_gnt}, 0);
        end

        // contention: data first after reset, then alternating
        @(negedge clk);
        instr_addr = 32'h10; instr_req = 1'b1;
        data_addr = 32'h20; data_rd_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("rr_dgnt", data_gnt, ((k % 4) == 1));
            chk("rr_ignt", instr_gnt, ((k % 4) == 3));
            if ((k % 4) == 1) chk("rr_ddata", data_rd_data, 32'hA000_0008);
            if ((k % 4) == 3) chk("rr_idata", instr_data, 32'hA000_0004);
        end
        instr_req = 1'b0; data_rd_req = 1'b0;

        // LED register with byte lanes
        data_acc(LED_A, 32'hFFFF_FFFF, 4'b0001, 1'b0, 1'b1);
        chk("led_wr_lat", lat, 1);
        chk("led_wr_men", men_seen, 0);
        chk("led_wr_val", led, 3'b111);
        data_acc(LED_A, 32'h0, 4'b0010, 1'b0, 1'b1);
        chk("led_lane1", led, 3'b111);
        data_acc(LED_A, 32'h0, 4'b0000, 1'b1, 1'b0);
        chk("led_rd", rd, 32'h0000_0007);
        chk("led_rd_men", men_seen, 0);
        data_acc(LED_A, 32'hFFFF_FFF5, 4'b0001, 1'b1, 1'b1);
        chk("led_rdwr_is_wr", led, 3'b101);
        chk("led_rdwr_data", rd, 0);

        // counter low/high coherency across a 32-bit wrap
        @(negedge clk);
        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFC0;
        @(negedge clk);
        release dut.cycle_cnt;
        data_acc(CLO_A, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("cnt_lo_pre", rd[31:8], 24'hFF_FFFF);
        repeat (80) @(negedge clk);
        data_acc(CHI_A, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("cnt_hi_shadow", rd, 0);
        data_acc(CLO_A, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("cnt_lo_post", rd[31:8], 0);
        data_acc(CHI_A, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("cnt_hi_post", rd, 1);
        data_acc(CLO_A, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("cnt_wr_lat", lat, 1);
        data_acc(CHI_A, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("cnt_wr_ignored", rd, 1);

        // memory write / read
        data_acc(32'h100, 32'hDEAD_BEEF, 4'b1100, 1'b0, 1'b1);
        chk("mw_men", men_seen, 1);
        chk("mw_wen", wen_seen, 1);
        chk("mw_addr", addr_seen, 10'h40);
        data_acc(32'h100, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("mr_addr", addr_seen, 10'h40);
        chk("mr_wen", wen_seen, 0);
        chk("mr_lat", lat, 1);
        chk("mr_data", rd, 32'hDEAD_0040);
        data_acc(32'hFFC, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("top_word_addr", addr_seen, 10'h3FF);
        chk("top_word_data", rd, 32'hA000_03FF);
        data_acc(32'h1000, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("past_mem_men", men_seen, 0);
        chk("past_mem_data", rd, 0);

        // unmapped accesses
        data_acc(32'h4000_0000, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("unm_rd_lat", lat, 1);
        chk("unm_rd_data", rd, 0);
        chk("unm_rd_men", men_seen, 0);
        data_acc(32'h4000_0000, 32'h1234_5678, 4'hF, 1'b0, 1'b1);
        chk("unm_wr_men", men_seen, 0);
        instr_acc(32'h9000_0000);
        chk("ifetch_unm_lat", lat, 1);
        chk("ifetch_unm_data", rd, 0);
        chk("ifetch_unm_men", men_seen, 0);
        instr_acc(LED_A);
        chk("ifetch_periph_data", rd, 0);
        instr_acc(32'h10);
        chk("ifetch_mem_lat", lat, 1);
        chk("ifetch_mem_data", rd, 32'hA000_0004);

        // idle outputs
        @(negedge clk); @(negedge clk);
        chk("idle_outs", {mem_en, instr_gnt, data_gnt, instr_data, data_rd_data}, 0);

        // reset in the middle of an access
        @(negedge clk);
        data_addr = 32'h100; data_rd_req = 1'b1;
        @(posedge clk); #1;
        chk("mid_gnt_before", data_gnt, 1);
        RSTN = 1'b0;
        #1;
        chk("mid_gnt_killed", data_gnt, 0);
        chk("mid_rstz", rstz, 0);
        chk("mid_led", led, 0);
        data_rd_req = 1'b0;
        @(negedge clk);
        RSTN = 1'b1;
        gnt_seen = 1'b0;
        repeat (8) @(negedge clk) if (instr_gnt || data_gnt) gnt_seen = 1'b1;
        chk("post_rst_no_gnt", gnt_seen, 0);
        chk("post_rst_rstz", rstz, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/icebreaker_system_fabric.md
ICEBREAKER_SYSTEM_FABRIC -- requirements
Module: icebreaker_system_fabric

Interface
REQ-001 SHALL have parameter MEM_AW, 10, EBR word-address width (memory = 4*2^MEM_AW bytes).
REQ-002 SHALL have parameter RST_STAGES, 2, reset synchronizer depth (>=2).
REQ-003 SHALL have parameter NUM_LED, 3, width of LED output register (1..32).
REQ-004 SHALL have port clk input 1 system clock; all logic on posedge.
REQ-005 SHALL have port RSTN input 1 reset: asynchronous, active-low.
REQ-006 SHALL have port rstz output 1 synchronized active-low reset for core.
REQ-007 SHALL have ports instr_addr input 32, instr_req input 1, instr_data output 32, instr_gnt output 1: fetch port.
REQ-008 SHALL have ports data_addr input 32, data_wr_data input 32, data_wr_mask input 4, data_rd_req input 1, data_wr_req input 1, data_rd_data output 32, data_gnt output 1: load/store port.
REQ-009 SHALL have ports mem_addr output MEM_AW, mem_wr_data output 32, mem_wr_mask output 4, mem_en output 1, mem_wr_en output 1, mem_rd_data input 32: EBR port, 1-cycle read latency.
REQ-010 SHALL have port led output NUM_LED, LED register contents.

Function
REQ-011 SHALL generate rstz via RST_STAGES flops: asserted asynchronously on RSTN low, deasserted after RST_STAGES rising clk edges of RSTN high.
REQ-012 SHALL hold all state (FSM, LED, counter, shadow, last-grant) at reset values while rstz low; no grants issued.
REQ-013 SHALL implement FSM IDLE -> IRESP (instr access) or DRESP (data access) -> IDLE; one transfer per 2 cycles.
REQ-014 SHALL, in IDLE, select a requester combinationally and drive mem_en/mem_addr/mem_wr_* in that same cycle for memory-region accesses.
REQ-015 SHALL, on simultaneous instr and data requests, grant round-robin: port not granted last; after reset, data wins first.
REQ-016 SHALL assert the selected gnt for exactly one cycle in IRESP/DRESP, with read data valid in that cycle.
REQ-017 SHALL rely on requesters holding addr/req/wr_* stable until gnt; request dropped before gnt is undefined.
REQ-018 SHALL decode region: addr < 4*2^MEM_AW -> memory; addr[31:28]==4'h8 -> peripheral (data port only); else unmapped.
REQ-019 SHALL map mem_addr = addr[MEM_AW+1:2]; mem_wr_en = data_wr_req; mem_wr_mask = data_wr_mask; mem_wr_data = data_wr_data.
REQ-020 SHALL treat data_rd_req and data_wr_req both high as a write.
REQ-021 SHALL provide peripheral 0x8000_0000 LED: RW, bits [NUM_LED-1:0], byte lanes per wr_mask; upper bits read 0.
REQ-022 SHALL provide 64-bit free-running cycle counter, +1 every cycle out of reset, wrapping 2^64-1 -> 0.
REQ-023 SHALL return counter[31:0] at 0x8000_0004 and latch counter[63:32] into shadow in the same access; 0x8000_0008 returns shadow.
REQ-024 SHALL ignore writes to counter addresses (grant still issued).
REQ-025 SHALL grant unmapped accesses and instr fetches outside memory after one cycle: read data 0, writes dropped, mem_en low.
REQ-026 SHALL keep mem_en low and instr_data/data_rd_data 0 outside a granting cycle.

Reset
REQ-027 SHALL on RSTN low immediately force: rstz=0, instr_gnt=0, data_gnt=0, mem_en=0, mem_wr_en=0, FSM=IDLE, led=0, counter=0, shadow=0, last-grant=instr.
REQ-028 SHALL abort any in-flight access on reset; no gnt for it after reset release.

Verification
REQ-029 SHALL verify: RSTN pulse low, release -> rstz rises exactly RST_STAGES edges later; no gnt before.
REQ-030 SHALL verify: instr_req and data_rd_req together to 0x10, 0x20 held -> data gnt first, then instr gnt, alternating thereafter.
REQ-031 SHALL verify: write 0x8000_0000 data 0xFFFF_FFFF mask 4'b0001 -> led=3'b111; readback 0x0000_0007; mem_en never high.
REQ-032 SHALL verify: counter preloaded near 0x0000_0000_FFFF_FFFF; read 0x..04 then 0x..08 -> high word equals value at low read, not later.
REQ-033 SHALL verify: memory write 0x100 data 0xDEAD_BEEF mask 4'b1100 then read -> mem_addr=0x40, read 0xDEAD_xxxx with 1-cycle latency.
REQ-034 SHALL verify: data read 0x4000_0000 and instr fetch 0x9000_0000 -> gnt after 1 cycle, data 0; RSTN low mid-access -> gnt suppressed.
